// File: rtl/mem_wb.sv
// MEM/WB pipeline register: latches MEM results for writeback under stall/flush
// control and counts instructions retired into WB.
module mem_wb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        stall,
   input  logic              flush,
   input  logic              mem_valid,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic [ADDR_W-1:0] mem_wd,
   input  logic              mem_wreg,
   input  logic              mem_whilo,
   input  logic [DATA_W-1:0] mem_hi,
   input  logic [DATA_W-1:0] mem_lo,
   input  logic              mem_llbit_we,
   input  logic              mem_llbit_value,
   output logic [DATA_W-1:0] wb_wdata,
   output logic [ADDR_W-1:0] wb_wd,
   output logic              wb_wreg,
   output logic              wb_whilo,
   output logic [DATA_W-1:0] wb_hi,
   output logic [DATA_W-1:0] wb_lo,
   output logic              wb_llbit_we,
   output logic              wb_llbit_value,
   output logic [CNT_W-1:0]  retire_cnt
);

   logic [DATA_W-1:0] r_wdata, r_hi, r_lo;
   logic [ADDR_W-1:0] r_wd;
   logic              r_wreg, r_whilo, r_llbit_we, r_llbit_value;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_bubble, w_capture;
   logic              w_unused_stall;

   // Only the MEM/WB stall bits matter here; stall[4]=0 always captures.
   assign w_bubble       = flush | (stall[4] & ~stall[5]);
   assign w_capture      = ~stall[4];
   assign w_unused_stall = ^stall[3:0];

   always_ff @(posedge clk) begin
      if (rst || w_bubble) begin
         r_wdata       <= '0;
         r_wd          <= '0;
         r_wreg        <= 1'b0;
         r_whilo       <= 1'b0;
         r_hi          <= '0;
         r_lo          <= '0;
         r_llbit_we    <= 1'b0;
         r_llbit_value <= 1'b0;
      end else if (w_capture) begin
         r_wdata       <= mem_wdata;
         r_wd          <= mem_wd;
         // $zero is never written, whatever MEM says
         r_wreg        <= mem_wreg & (mem_wd != '0);
         r_whilo       <= mem_whilo;
         r_hi          <= mem_hi;
         r_lo          <= mem_lo;
         r_llbit_we    <= mem_llbit_we;
         r_llbit_value <= mem_llbit_value;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_cnt <= '0;
      else if (!w_bubble && w_capture && mem_valid)
         r_cnt <= r_cnt + 1'b1;
   end

   assign wb_wdata       = r_wdata;
   assign wb_wd          = r_wd;
   assign wb_wreg        = r_wreg;
   assign wb_whilo       = r_whilo;
   assign wb_hi          = r_hi;
   assign wb_lo          = r_lo;
   assign wb_llbit_we    = r_llbit_we;
   assign wb_llbit_value = r_llbit_value;
   assign retire_cnt     = r_cnt;

endmodule

// File: tb/tb_mem_wb.sv
// Scoreboard bench for mem_wb: directed vectors push hand-computed results,
// a monitor pops and compares one cycle after each vector is applied.
module tb_mem_wb;

   typedef struct {
      logic        r;
      logic        f;
      logic [5:0]  st;
      logic        v;
      logic [31:0] wdata;
      logic [4:0]  wd;
      logic        wreg;
      logic        whilo;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        llwe;
      logic        llv;
   } stim_t;

   typedef struct {
      string       name;
      logic [31:0] wdata;
      logic [4:0]  wd;
      logic        wreg;
      logic        whilo;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        llwe;
      logic        llv;
      logic [31:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, flush, mem_valid, mem_wreg, mem_whilo, mem_llbit_we, mem_llbit_value;
   logic [5:0]  stall;
   logic [31:0] mem_wdata, mem_hi, mem_lo;
   logic [4:0]  mem_wd;

   logic [31:0] wb_wdata, wb_hi, wb_lo, retire_cnt;
   logic [4:0]  wb_wd;
   logic        wb_wreg, wb_whilo, wb_llbit_we, wb_llbit_value;

   // narrow-counter instance sharing the same stimulus, to exercise wrap
   logic [31:0] s_wdata, s_hi, s_lo;
   logic [4:0]  s_wd;
   logic        s_wreg, s_whilo, s_llwe, s_llv;
   logic [2:0]  s_cnt;

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   mem_wb u_dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
      .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_whilo(mem_whilo),
      .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_llbit_we(mem_llbit_we),
      .mem_llbit_value(mem_llbit_value),
      .wb_wdata(wb_wdata), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_whilo(wb_whilo),
      .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_llbit_we(wb_llbit_we),
      .wb_llbit_value(wb_llbit_value), .retire_cnt(retire_cnt)
   );

   mem_wb #(.CNT_W(3)) u_dut_w (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
      .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_whilo(mem_whilo),
      .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_llbit_we(mem_llbit_we),
      .mem_llbit_value(mem_llbit_value),
      .wb_wdata(s_wdata), .wb_wd(s_wd), .wb_wreg(s_wreg), .wb_whilo(s_whilo),
      .wb_hi(s_hi), .wb_lo(s_lo), .wb_llbit_we(s_llwe),
      .wb_llbit_value(s_llv), .retire_cnt(s_cnt)
   );

   task automatic cyc(input stim_t s, input exp_t e);
      @(negedge clk);
      rst = s.r; flush = s.f; stall = s.st; mem_valid = s.v;
      mem_wdata = s.wdata; mem_wd = s.wd; mem_wreg = s.wreg; mem_whilo = s.whilo;
      mem_hi = s.hi; mem_lo = s.lo; mem_llbit_we = s.llwe; mem_llbit_value = s.llv;
      sb.push_back(e);
   endtask

   // monitor: the register presents a new result every cycle
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            if (wb_wdata === e.wdata && wb_wd === e.wd && wb_wreg === e.wreg &&
                wb_whilo === e.whilo && wb_hi === e.hi && wb_lo === e.lo &&
                wb_llbit_we === e.llwe && wb_llbit_value === e.llv && retire_cnt === e.cnt)
               n_pass++;
            else
               $display("FAIL %s: got wdata=%h wd=%0d wreg=%b whilo=%b hi=%h lo=%h llwe=%b llv=%b cnt=%0d, want wdata=%h wd=%0d wreg=%b whilo=%b hi=%h lo=%h llwe=%b llv=%b cnt=%0d",
                        e.name, wb_wdata, wb_wd, wb_wreg, wb_whilo, wb_hi, wb_lo, wb_llbit_we,
                        wb_llbit_value, retire_cnt, e.wdata, e.wd, e.wreg, e.whilo, e.hi, e.lo,
                        e.llwe, e.llv, e.cnt);
            n_checks++;
            if (s_cnt === e.cnt[2:0] && s_wd === e.wd && s_wreg === e.wreg)
               n_pass++;
            else
               $display("FAIL %s_narrow: got cnt=%0d wd=%0d wreg=%b, want cnt=%0d wd=%0d wreg=%b",
                        e.name, s_cnt, s_wd, s_wreg, e.cnt[2:0], e.wd, e.wreg);
         end
      end
   end

   localparam logic [5:0] S_NONE = 6'b000000;
   localparam logic [5:0] S_MEM  = 6'b010000;
   localparam logic [5:0] S_BOTH = 6'b110000;
   localparam logic [5:0] S_ILL  = 6'b100000;

   initial begin
      // reset with busy inputs
      cyc('{1,0,S_NONE,1,32'hAA,5'd9,1,1,32'h1,32'h2,1,1}, '{"rst0",0,0,0,0,0,0,0,0,0});
      cyc('{1,0,S_NONE,1,32'hAA,5'd9,1,1,32'h1,32'h2,1,1}, '{"rst1",0,0,0,0,0,0,0,0,0});
      cyc('{0,0,S_NONE,1,32'hDEADBEEF,5'd5,1,0,0,0,0,0},
          '{"first",32'hDEADBEEF,5'd5,1,0,0,0,0,0,1});
      // back-to-back stream, HI/LO on the third
      cyc('{0,0,S_NONE,1,32'h101,5'd1,1,0,0,0,0,0}, '{"str1",32'h101,5'd1,1,0,0,0,0,0,2});
      cyc('{0,0,S_NONE,1,32'h102,5'd2,1,0,0,0,0,0}, '{"str2",32'h102,5'd2,1,0,0,0,0,0,3});
      cyc('{0,0,S_NONE,1,32'h103,5'd3,1,1,32'h11,32'h22,0,0},
          '{"str3",32'h103,5'd3,1,1,32'h11,32'h22,0,0,4});
      cyc('{0,0,S_NONE,1,32'h104,5'd4,1,0,0,0,0,0}, '{"str4",32'h104,5'd4,1,0,0,0,0,0,5});
      // bubble on MEM-only stall
      cyc('{0,0,S_NONE,1,32'h77,5'd7,1,0,0,0,0,0}, '{"cap7",32'h77,5'd7,1,0,0,0,0,0,6});
      cyc('{0,0,S_MEM,1,32'h88,5'd8,1,1,32'h5,32'h6,1,1}, '{"bubble",0,0,0,0,0,0,0,0,6});
      // hold on full stall with changing inputs
      cyc('{0,0,S_NONE,1,32'h70,5'd7,1,1,32'h33,32'h44,0,0},
          '{"cap7b",32'h70,5'd7,1,1,32'h33,32'h44,0,0,7});
      cyc('{0,0,S_BOTH,1,32'hA1,5'd9,0,0,32'h1,32'h1,1,1},
          '{"hold1",32'h70,5'd7,1,1,32'h33,32'h44,0,0,7});
      cyc('{0,0,S_BOTH,0,32'hA2,5'd10,1,0,32'h2,32'h2,1,0},
          '{"hold2",32'h70,5'd7,1,1,32'h33,32'h44,0,0,7});
      cyc('{0,0,S_BOTH,1,32'hA3,5'd11,1,1,32'h3,32'h3,0,1},
          '{"hold3",32'h70,5'd7,1,1,32'h33,32'h44,0,0,7});
      // flush wins over full stall
      cyc('{0,1,S_BOTH,1,32'hB1,5'd12,1,1,32'h9,32'h9,1,1}, '{"flush",0,0,0,0,0,0,0,0,7});
      // $zero destination, narrow counter wraps 7 -> 0 here
      cyc('{0,0,S_NONE,1,32'h1234,5'd0,1,0,0,0,0,0}, '{"zero",32'h1234,5'd0,0,0,0,0,0,0,8});
      cyc('{0,0,S_NONE,1,32'h33,5'd3,1,0,0,0,1,1}, '{"llbit",32'h33,5'd3,1,0,0,0,1,1,9});
      // invalid slot propagates enables but does not count
      cyc('{0,0,S_NONE,0,32'h44,5'd4,1,0,0,0,0,0}, '{"novalid",32'h44,5'd4,1,0,0,0,0,0,9});
      // illegal stall combination captures
      cyc('{0,0,S_ILL,1,32'h66,5'd6,1,0,0,0,0,0}, '{"illegal",32'h66,5'd6,1,0,0,0,0,0,10});
      cyc('{0,1,S_NONE,1,32'h67,5'd6,1,0,0,0,0,0}, '{"flush2",0,0,0,0,0,0,0,0,10});
      // reset mid-stall, then normal capture
      cyc('{0,0,S_NONE,1,32'h55,5'd5,1,1,32'h7,32'h8,1,0},
          '{"cap5",32'h55,5'd5,1,1,32'h7,32'h8,1,0,11});
      cyc('{1,0,S_BOTH,1,32'h99,5'd9,1,1,32'h7,32'h8,1,1}, '{"rst_stall",0,0,0,0,0,0,0,0,0});
      cyc('{0,0,S_NONE,1,32'h22,5'd2,1,0,0,0,0,0}, '{"after_rst",32'h22,5'd2,1,0,0,0,0,0,1});
      cyc('{0,0,S_MEM,0,0,0,0,0,0,0,0,0}, '{"idle",0,0,0,0,0,0,0,0,1});

      // drain, bounded
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d entries left, want 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
